// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux round-robin sequencer.
// Optional feature macro: DEMUX_SEQ_CONT_EN (continuous re-sweep while start is held).
package demux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Widest mask the helper accepts; callers zero-extend narrower masks.
  localparam int unsigned MAX_CH = 32;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [4:0] first_set(input logic [MAX_CH-1:0] mask);
    logic found;
    first_set = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (mask[i] && !found) begin
        first_set = i[4:0];
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/demux_next_ch.sv
// Finds the next enabled channel strictly above the current select.
// Optional feature macro: none (see demux_rr_sequencer for DEMUX_SEQ_CONT_EN).
module demux_next_ch #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              none
);

  // Scan upward from cur+1 and stop at the first enabled channel.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (none && (i > 32'(cur)) && mask[i]) begin
        nxt  = SEL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin sequencer driving the 1-to-4 demux select and data bit.
// Optional feature macro: DEMUX_SEQ_CONT_EN -- when defined, a sweep that ends
// with start held wraps back to the lowest enabled channel instead of finishing.
module demux_rr_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               data_in,
  output logic [SEL_W-1:0]   sel,
  output logic               demux_in,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               din_q, din_d;

  logic [SEL_W-1:0]   nxt_ch;
  logic               nxt_none;
  logic [SEL_W-1:0]   first_req;
  logic [SEL_W-1:0]   first_lat;
  logic               last_beat;

  demux_next_ch #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next_ch (
    .mask (mask_q),
    .cur  (sel_q),
    .nxt  (nxt_ch),
    .none (nxt_none)
  );

  assign first_req = SEL_W'(first_set(MAX_CH'(ch_mask)));
  assign first_lat = SEL_W'(first_set(MAX_CH'(mask_q)));
  assign last_beat = (cnt_q == (dwell_q - DWELL_W'(1)));

  // State and datapath registers; reset clears everything, including mid-sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      din_q   <= din_d;
    end
  end

  // Next-state, channel advance and dwell counting; abort takes priority in ACTIVE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        cnt_d = '0;
        if (start) begin
          if (ch_mask != '0) begin
            state_d = ACTIVE;
            mask_d  = ch_mask;
            dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
            sel_d   = first_req;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (last_beat) begin
          cnt_d = '0;
          if (!nxt_none) begin
            sel_d = nxt_ch;
          end else begin
`ifdef DEMUX_SEQ_CONT_EN
            if (start) sel_d = first_lat;
            else       state_d = DONE;
`else
            state_d = DONE;
`endif
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
    din_d = (state_d == ACTIVE) ? data_in : 1'b0;
  end

`ifndef DEMUX_SEQ_CONT_EN
  logic unused_first_lat;
  assign unused_first_lat = ^first_lat;
`endif

  assign sel      = sel_q;
  assign demux_in = din_q;
  assign valid    = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE) || (state_q == DONE);
  assign done     = (state_q == DONE);

endmodule
